// File: rtl/depth_fifo.sv
// depth_fifo: valid/ready FIFO with arbitrary depth.
// Ports: clk, rst, in_valid/in_ready/in_data, out_valid/out_ready/out_data, count.
module depth_fifo #(
  parameter int Width = 32,
  parameter int Depth = 500
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [Width-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [Width-1:0] out_data,
  output int               count
);

  localparam int PTR_WIDTH =
    ($clog2(Depth) > 1) ? $clog2(Depth) : 1;
  localparam int CNT_W = $clog2(Depth + 1);

  localparam logic [PTR_WIDTH-1:0] LAST_PTR =
    PTR_WIDTH'(Depth - 1);
  localparam logic [CNT_W-1:0] FULL_CNT =
    CNT_W'(Depth);

  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  // Pointers wrap explicitly at Depth-1,
  // so non-power-of-two depths never alias.
  function automatic logic [PTR_WIDTH-1:0] ptr_inc(
    input logic [PTR_WIDTH-1:0] p
  );
    return (p == LAST_PTR) ? '0 : p + PTR_WIDTH'(1);
  endfunction

  // Flags come from registered state only:
  // no path from in_valid or out_ready.
  assign in_ready  = (r_count != FULL_CNT);
  assign out_valid = (r_count != '0);
  assign w_push    = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;
  assign count     = int'(32'(r_count));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else begin
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  if (Depth > 2) begin : gen_block
    logic [Width-1:0]     r_mem [Depth];
    logic [PTR_WIDTH-1:0] r_wr_ptr;
    logic [PTR_WIDTH-1:0] r_rd_ptr;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
        if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
    end

    // Storage is never cleared; stale
    // words are unreachable after reset.
    always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= in_data;
    end

    assign out_data = r_mem[r_rd_ptr];

  end else if (Depth == 2) begin : gen_slot2
    logic [Width-1:0]     r_slot0;
    logic [Width-1:0]     r_slot1;
    logic [PTR_WIDTH-1:0] r_wr_ptr;
    logic [PTR_WIDTH-1:0] r_rd_ptr;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
        if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
    end

    always_ff @(posedge clk) begin
      if (w_push) begin
        if (r_wr_ptr == '0) r_slot0 <= in_data;
        else                r_slot1 <= in_data;
      end
    end

    assign out_data = (r_rd_ptr == '0) ? r_slot0
                                       : r_slot1;

  end else begin : gen_slot1
    // One slot: full whenever valid, so
    // throughput is one word per two cycles.
    logic [Width-1:0] r_slot0;

    always_ff @(posedge clk) begin
      if (w_push) r_slot0 <= in_data;
    end

    assign out_data = r_slot0;
  end

endmodule
